// File: rtl/alu_muldiv_unit.sv
// Multi-cycle signed multiply/divide unit with architectural HI/LO registers.
// Runs one shift-add (mult) or restoring shift-subtract (div) step per cycle
// on operand magnitudes, then applies the sign fix-up and writes HI/LO.
module alu_muldiv_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter logic [4:0]  CODE_MULT = 5'b01001,
    parameter logic [4:0]  CODE_DIV  = 5'b01110,
    parameter logic [4:0]  CODE_MFHI = 5'b01010,
    parameter logic [4:0]  CODE_MFLO = 5'b10011
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       alu_ctrl,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e               state_q;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     mcand_q;   // |op_b|: multiplicand or divisor
    logic [2*WIDTH-1:0]   prod_q;    // upper: partial sum, lower: remaining multiplier bits
    logic [WIDTH-1:0]     quot_q;    // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]     rem_q;
    logic                 neg_q_q;
    logic                 neg_r_q;
    logic                 is_div_q;

    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   prod_neg;
    logic                 accept;
    logic                 last_step;

    // Operand magnitudes, per-step datapath and read/stall outputs.
    always_comb begin
        a_abs     = op_a[WIDTH-1] ? -op_a : op_a;
        b_abs     = op_b[WIDTH-1] ? -op_b : op_b;
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                    (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        div_shift = {rem_q, quot_q[WIDTH-1]};
        // Bit WIDTH of the difference set means the trial subtraction went negative.
        div_diff  = div_shift - {1'b0, mcand_q};
        prod_neg  = -prod_q;
        accept    = start && (state_q == StIdle) &&
                    (alu_ctrl == CODE_MULT || alu_ctrl == CODE_DIV);
        last_step = (cnt_q == CW'(WIDTH - 1));
        busy      = (state_q != StIdle);
        stall     = busy && (alu_ctrl == CODE_MULT || alu_ctrl == CODE_DIV ||
                             alu_ctrl == CODE_MFHI || alu_ctrl == CODE_MFLO);
        if (alu_ctrl == CODE_MFHI) begin
            result = hi;
        end else if (alu_ctrl == CODE_MFLO) begin
            result = lo;
        end else begin
            result = '0;
        end
    end

    // Sequencer and datapath registers; HI/LO change only in the fix-up cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mcand_q     <= '0;
            prod_q      <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            is_div_q    <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        mcand_q     <= b_abs;
                        prod_q      <= {{WIDTH{1'b0}}, a_abs};
                        quot_q      <= a_abs;
                        rem_q       <= '0;
                        neg_q_q     <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        neg_r_q     <= op_a[WIDTH-1];
                        is_div_q    <= (alu_ctrl == CODE_DIV);
                        div_by_zero <= (alu_ctrl == CODE_DIV) && (op_b == '0);
                        cnt_q       <= '0;
                        state_q     <= (alu_ctrl == CODE_DIV) ? StDiv : StMul;
                    end
                end
                StMul: begin
                    prod_q <= {mul_sum, prod_q[WIDTH-1:1]};
                    cnt_q  <= cnt_q + 1'b1;
                    if (last_step) state_q <= StFix;
                end
                StDiv: begin
                    quot_q <= {quot_q[WIDTH-2:0], ~div_diff[WIDTH]};
                    rem_q  <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                    cnt_q  <= cnt_q + 1'b1;
                    if (last_step) state_q <= StFix;
                end
                StFix: begin
                    if (is_div_q) begin
                        // Zero divisor yields all-ones quotient; remainder fix-up
                        // restores the original dividend.
                        lo <= div_by_zero ? {WIDTH{1'b1}} : (neg_q_q ? -quot_q : quot_q);
                        hi <= neg_r_q ? -rem_q : rem_q;
                    end else begin
                        {hi, lo} <= neg_q_q ? prod_neg : prod_q;
                    end
                    done    <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
